// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes LANES bytes of a 128-bit state per cycle and
// presents the finished state behind a ready/valid handshake. Byte 0 is the most significant byte.
`timescale 1ns/1ps
module sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int STEPS = 16 / LANES;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_cnt, w_cnt_next;
   logic [127:0]    r_work, w_work_next;
   logic [127:0]    r_out, w_out_next;
   logic            r_out_valid, w_out_valid_next;
   logic [3:0]      w_base;
   logic [6:0]      w_pos    [LANES];
   logic [7:0]      w_sb_in  [LANES];
   logic [7:0]      w_sb_out [LANES];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as x^254 (0 maps to 0), then the AES affine transform.
   function automatic logic [7:0] s_box(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = x;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]} ^
             {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
   endfunction

   generate
      if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
         $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   assign w_base = 4'(int'(r_cnt) * LANES);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_pos[gi]    = {4'd15 - (w_base + 4'(gi)), 3'b000};
         assign w_sb_in[gi]  = r_work[w_pos[gi] +: 8];
         assign w_sb_out[gi] = s_box(w_sb_in[gi]);
      end
   endgenerate

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_work_next      = r_work;
      w_out_next       = r_out;
      w_out_valid_next = r_out_valid;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_work_next  = in_data;
               w_cnt_next   = '0;
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            for (int k = 0; k < LANES; k++) begin
               w_work_next[w_pos[k] +: 8] = w_sb_out[k];
            end
            if (r_cnt == LAST) begin
               w_cnt_next       = '0;
               w_out_next       = w_work_next;
               w_out_valid_next = 1'b1;
               w_state_next     = S_DONE;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_out_valid_next = 1'b0;
               w_state_next     = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_work      <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_work      <= w_work_next;
         r_out       <= w_out_next;
         r_out_valid <= w_out_valid_next;
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_BUSY);
   assign out_valid = r_out_valid;
   assign out_data  = r_out;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: three instances (LANES 4, 1, 16) sharing one clock and reset,
// directed AES vectors, and a scoreboard monitor that checks every output handshake.
`timescale 1ns/1ps
module tb_sub_bytes_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid_a  [3];
   logic         in_ready_a  [3];
   logic [127:0] in_data_a   [3];
   logic         out_valid_a [3];
   logic         out_ready_a [3];
   logic [127:0] out_data_a  [3];
   logic         busy_a      [3];

   int lat_exp [3];
   int n_cmp;
   int n_err;
   int cyc;

   typedef struct {
      int           sel;
      logic [127:0] data;
   } exp_t;
   exp_t exp_q [$];
   exp_t mon_e;

   localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V1_IN    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] V1_OUT   = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] V2_IN    = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] V2_OUT   = 128'hca82c97dfa5947f0add4a2af9ca472c0;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         sub_bytes_iter #(.LANES((gi == 0) ? 4 : ((gi == 1) ? 1 : 16))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .in_data   (in_data_a[gi]),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready_a[gi]),
            .out_data  (out_data_a[gi]),
            .busy      (busy_a[gi])
         );
      end
   endgenerate

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_b(input string name, input int s, input logic got, input logic want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s inst=%0d: got %b, expected %b", name, s, got, want);
      end
   endtask

   task automatic check_w(input string name, input int s, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s inst=%0d: got %h, expected %h", name, s, got, want);
      end
   endtask

   task automatic check_i(input string name, input int s, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s inst=%0d: got %0d, expected %0d", name, s, got, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issues one state, pushes its expected result and checks busy and latency.
   // Returns at the falling edge on which out_valid was first seen.
   task automatic send(input int s, input logic [127:0] d, input logic [127:0] e,
                       input bit hold, output int acc);
      int guard;
      int lat;
      exp_t item;
      guard = 0;
      acc   = -1;
      while (in_ready_a[s] !== 1'b1 && guard < 50) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (in_ready_a[s] !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout inst=%0d: in_ready stayed low for %0d cycles", s, guard);
         return;
      end
      in_valid_a[s] = 1'b1;
      in_data_a[s]  = d;
      @(posedge clk);
      item.sel  = s;
      item.data = e;
      exp_q.push_back(item);
      #1;
      acc = cyc;
      if (!hold) in_valid_a[s] = 1'b0;
      @(negedge clk);
      check_b("busy_after_accept", s, busy_a[s], 1'b1);
      check_b("no_early_valid", s, out_valid_a[s], 1'b0);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid_a[s] === 1'b1) break;
      end
      check_i("latency", s, lat, lat_exp[s]);
      $display("txn in  inst=%0d data=%h latency=%0d", s, d, lat);
   endtask

   // Scoreboard monitor: a handshake happens at the next rising edge.
   always @(negedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (rst_n === 1'b1 && out_valid_a[s] === 1'b1 && out_ready_a[s] === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output inst=%0d: got %h, expected no output", s, out_data_a[s]);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.sel != s || out_data_a[s] !== mon_e.data) begin
                  n_err++;
                  $display("FAIL out_data inst=%0d: got %h, expected %h from inst %0d",
                           s, out_data_a[s], mon_e.data, mon_e.sel);
               end else begin
                  $display("txn out inst=%0d data=%h ok", s, out_data_a[s]);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sb_in  [5];
      logic [7:0] sb_out [5];
      int acc0, acc1, acc2;

      sb_in   = '{8'h09, 8'h98, 8'haf, 8'h00, 8'h53};
      sb_out  = '{8'h01, 8'h46, 8'h79, 8'h63, 8'hed};
      lat_exp = '{4, 16, 1};
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_valid_a[s]  = 1'b0;
         in_data_a[s]   = '0;
         out_ready_a[s] = 1'b1;
      end

      #2;
      for (int s = 0; s < 3; s++) begin
         check_b("reset_in_ready", s, in_ready_a[s], 1'b1);
         check_b("reset_out_valid", s, out_valid_a[s], 1'b0);
         check_w("reset_out_data", s, out_data_a[s], '0);
         check_b("reset_busy", s, busy_a[s], 1'b0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Uniform single-byte states on the LANES=4 instance.
      for (int i = 0; i < 5; i++) begin
         send(0, {16{sb_in[i]}}, {16{sb_out[i]}}, 1'b0, acc0);
      end
      send(0, FIPS_IN, FIPS_OUT, 1'b0, acc0);

      // Back-pressure: result must hold while out_ready is low; in_valid pulse ignored.
      idle(2);
      out_ready_a[0] = 1'b0;
      send(0, V2_IN, V2_OUT, 1'b0, acc0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         in_valid_a[0] = (i == 3);
         in_data_a[0]  = FIPS_IN;
         @(negedge clk);
         check_w("hold_out_data", 0, out_data_a[0], V2_OUT);
         check_b("hold_out_valid", 0, out_valid_a[0], 1'b1);
         check_b("hold_in_ready", 0, in_ready_a[0], 1'b0);
      end
      @(posedge clk);
      #1;
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check_b("idle_after_release", 0, in_ready_a[0], 1'b1);
      check_b("valid_after_release", 0, out_valid_a[0], 1'b0);
      send(0, FIPS_IN, FIPS_OUT, 1'b0, acc0);

      // Back-to-back with in_valid held: accepts spaced 16/LANES+2 cycles.
      idle(2);
      send(0, V1_IN, V1_OUT, 1'b1, acc0);
      send(0, V2_IN, V2_OUT, 1'b1, acc1);
      send(0, FIPS_IN, FIPS_OUT, 1'b0, acc2);
      check_i("b2b_spacing_1", 0, acc1 - acc0, 6);
      check_i("b2b_spacing_2", 0, acc2 - acc1, 6);

      // Asynchronous reset two edges into BUSY discards the in-flight state.
      idle(2);
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = V2_IN;
      @(posedge clk);
      #1;
      in_valid_a[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_b("pre_reset_busy", 0, busy_a[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check_b("async_out_valid", 0, out_valid_a[0], 1'b0);
      check_w("async_out_data", 0, out_data_a[0], '0);
      check_b("async_in_ready", 0, in_ready_a[0], 1'b1);
      check_b("async_busy", 0, busy_a[0], 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(0, V1_IN, V1_OUT, 1'b0, acc0);

      // FIPS vector on the LANES=1 and LANES=16 instances.
      idle(2);
      send(1, FIPS_IN, FIPS_OUT, 1'b0, acc0);
      idle(2);
      send(2, FIPS_IN, FIPS_OUT, 1'b0, acc0);

      idle(5);
      check_i("scoreboard_drained", 0, exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
